serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/alu_pkg.sv | 13 +
 rtl/add_1b.sv | 13 +
 rtl/serial_addsub.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding and
// the default operand width.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/add_1b.sv
// Single-bit full adder cell used by the serial add/subtract datapath.
module add_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first,
// through a single full-adder cell with a registered carry. Subtraction
// is A + ~B + 1, so the carry is preset to 1 and B is inverted on load.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             load_en;
  logic             run_en;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] result_nxt;

  add_1b u_add_1b (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign result_nxt = {fa_s, result[WIDTH-1:1]};

  // Next-state logic and status outputs; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    run_en    = 1'b0;
    last_bit  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_en   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        run_en   = 1'b1;
        last_bit = (cnt == LAST_CNT);
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bit counter and running carry; the counter holds at its last value so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (load_en) begin
      cnt   <= '0;
      carry <= sub;
    end else if (run_en) begin
      carry <= fa_c;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // Operand shift registers; B is pre-inverted for subtraction.
  always_ff @(posedge clk) begin
    if (load_en) begin
      sa <= a;
      sb <= b ^ {WIDTH{sub}};
    end else if (run_en) begin
      sa <= {1'b0, sa[WIDTH-1:1]};
      sb <= {1'b0, sb[WIDTH-1:1]};
    end
  end

  // Result shifts in from the MSB; flags are captured on the final bit and held.
  // The carry register at the final bit is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (load_en) begin
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (run_en) begin
      result <= result_nxt;
      if (last_bit) begin
        cout     <= fa_c;
        overflow <= carry ^ fa_c;
        zero     <= (result_nxt == '0);
      end
    end
  end

endmodule
